// File: rtl/operand_stream_unit_pkg.sv
// nn_pkg: shared defaults, FSM state type and table select codes for the operand stream unit.
package nn_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
    localparam logic TBL_INPUT  = 1'b0;
    localparam logic TBL_WEIGHT = 1'b1;
endpackage

// File: rtl/operand_stream_unit_if.sv
// operand_stream_unit_if: valid/ready pair stream from the operand unit to the MAC datapath.
interface operand_stream_unit_if #(parameter int DATA_W = 8);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_input;
    logic [DATA_W-1:0] out_weight;
    logic              out_last;
    modport master (output out_valid, out_input, out_weight, out_last, input out_ready);
    modport slave  (input out_valid, out_input, out_weight, out_last, output out_ready);
endinterface

// File: rtl/operand_stream_unit_vector_bank.sv
// vector_bank: one table, synchronous write port and asynchronous read port; contents are not reset.
module vector_bank #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 16,
    parameter int DEPTH  = 2 ** IDX_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/operand_stream_unit.sv
// operand_stream_unit: streams length (input, weight) pairs from base_addr to the MAC over valid/ready.
// Define OPERAND_STREAM_TRACE_EN to print every accepted beat in simulation.
module operand_stream_unit
    import nn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    operand_stream_unit_if.master s
);
    localparam int IW = $clog2(DEPTH);

    function automatic logic [IW-1:0] wrap(input logic [ADDR_W-1:0] a);
        return IW'(32'(a) % 32'(DEPTH));
    endfunction

    state_t            state;
    logic [IW-1:0]     rd_addr;
    logic [ADDR_W:0]   remaining;
    logic [IW-1:0]     wr_idx;
    logic [DATA_W-1:0] rd_in, rd_wt;
    logic              load;

    assign wr_idx = wrap(wr_addr);
    assign load   = state == STREAM && remaining != '0 && (!s.out_valid || s.out_ready);

    vector_bank #(.DATA_W(DATA_W), .IDX_W(IW), .DEPTH(DEPTH)) u_in (
        .clk, .we(wr_en && wr_sel == TBL_INPUT), .waddr(wr_idx), .wdata(wr_data),
        .raddr(rd_addr), .rdata(rd_in)
    );

    vector_bank #(.DATA_W(DATA_W), .IDX_W(IW), .DEPTH(DEPTH)) u_wt (
        .clk, .we(wr_en && wr_sel == TBL_WEIGHT), .waddr(wr_idx), .wdata(wr_data),
        .raddr(rd_addr), .rdata(rd_wt)
    );

    // FINISH is entered with busy still high only for an empty stream, which then spends one extra cycle there
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_addr      <= '0;
            remaining    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            s.out_valid  <= 1'b0;
            s.out_last   <= 1'b0;
            s.out_input  <= '0;
            s.out_weight <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rd_addr   <= wrap(base_addr);
                    remaining <= length;
                    busy      <= 1'b1;
                    state     <= length != '0 ? STREAM : FINISH;
                end
                STREAM: if (load) begin
                    s.out_valid  <= 1'b1;
                    s.out_last   <= remaining == (ADDR_W+1)'(1);
                    s.out_input  <= rd_in;
                    s.out_weight <= rd_wt;
                    rd_addr      <= rd_addr == IW'(DEPTH - 1) ? '0 : rd_addr + 1'b1;
                    remaining    <= remaining - 1'b1;
                end else if (s.out_valid && s.out_ready && s.out_last) begin
                    s.out_valid <= 1'b0;
                    s.out_last  <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= FINISH;
                end
                FINISH: begin
                    done  <= busy;
                    busy  <= 1'b0;
                    state <= busy ? FINISH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OPERAND_STREAM_TRACE_EN
    always_ff @(posedge clk)
        if (s.out_valid && s.out_ready)
            $display("@%t: out_input_vector=%d, out_weight_vector=%d", $time, s.out_input, s.out_weight);
`endif
endmodule

// File: tb/tb_operand_stream_unit.sv
// tb_operand_stream_unit: table-driven stream checks plus hand-written reset and collision sequences.
module tb_operand_stream_unit;
    typedef struct {
        int base;
        int len;
        int mode;
        int fi;
        int fw;
        int li;
        int lw;
    } vec_t;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       wr_en = 0;
    logic       wr_sel = 0;
    logic [7:0] wr_addr = 0;
    logic [7:0] wr_data = 0;
    logic       start = 0;
    logic [7:0] base_addr = 0;
    logic [8:0] length = 0;
    logic       busy, done;
    logic [7:0] m_in [16];
    logic [7:0] m_wt [16];
    vec_t       vt [8];
    int         total = 0;
    int         bad = 0;

    operand_stream_unit_if #(.DATA_W(8)) s ();

    operand_stream_unit #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .s(s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input int idx);
        vec_t       v;
        int         beats = 0, cyc = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1, done_busy = 0, a;
        logic [7:0] h_in = 0, h_wt = 0;
        logic       h_last = 0, stalled = 0;
        v = vt[idx];
        @(negedge clk);
        base_addr   = 8'(v.base);
        length      = 9'(v.len);
        start       = 1;
        s.out_ready = 0;
        @(negedge clk);
        start = 0;
        chk($sformatf("v%0d busy_after_start", idx), busy, 1);
        while (done_cyc < 0 && cyc < 100) begin
            if (stalled) begin
                chk($sformatf("v%0d stall_valid", idx), s.out_valid, 1);
                chk($sformatf("v%0d stall_in", idx), s.out_input, h_in);
                chk($sformatf("v%0d stall_wt", idx), s.out_weight, h_wt);
                chk($sformatf("v%0d stall_last", idx), s.out_last, h_last);
            end
            s.out_ready = v.mode == 1 ? (cyc % 3 == 0) : 1'b1;
            wr_en   = v.mode == 2 && cyc == 5;
            wr_sel  = 1;
            wr_addr = 5;
            wr_data = 99;
            start   = v.mode == 2 && cyc == 3;
            if (s.out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (s.out_ready) begin
                    a = (v.base + beats) % 16;
                    chk($sformatf("v%0d b%0d in", idx, beats), s.out_input, m_in[a]);
                    chk($sformatf("v%0d b%0d wt", idx, beats), s.out_weight, m_wt[a]);
                    chk($sformatf("v%0d b%0d last", idx, beats), s.out_last, beats == v.len - 1);
                    if (beats == 0) begin
                        chk($sformatf("v%0d first_in", idx), s.out_input, v.fi);
                        chk($sformatf("v%0d first_wt", idx), s.out_weight, v.fw);
                    end
                    if (beats == v.len - 1) begin
                        chk($sformatf("v%0d last_in", idx), s.out_input, v.li);
                        chk($sformatf("v%0d last_wt", idx), s.out_weight, v.lw);
                        last_cyc = cyc;
                    end
                    beats++;
                end
            end
            stalled = s.out_valid && !s.out_ready;
            h_in    = s.out_input;
            h_wt    = s.out_weight;
            h_last  = s.out_last;
            if (done) begin
                done_cyc  = cyc;
                done_busy = busy;
            end
            @(negedge clk);
            cyc++;
        end
        wr_en = 0;
        start = 0;
        chk($sformatf("v%0d done_seen", idx), done_cyc >= 0, 1);
        chk($sformatf("v%0d beats", idx), beats, v.len);
        chk($sformatf("v%0d busy_at_done", idx), done_busy, 0);
        if (v.len > 0) begin
            chk($sformatf("v%0d first_latency", idx), first_cyc, 1);
            chk($sformatf("v%0d done_timing", idx), done_cyc, last_cyc + 1);
        end else begin
            chk($sformatf("v%0d empty_done_timing", idx), done_cyc, 1);
            chk($sformatf("v%0d empty_no_valid", idx), first_cyc, -1);
        end
        chk($sformatf("v%0d done_pulse", idx), done, 0);
        chk($sformatf("v%0d busy_after", idx), busy, 0);
        if (v.mode == 2) m_wt[5] = 99;
    endtask

    initial begin
        vt[0] = '{0, 8, 0, 1, 0, 8, 14};
        vt[1] = '{0, 8, 1, 1, 0, 8, 14};
        vt[2] = '{14, 4, 0, 15, 28, 2, 2};
        vt[3] = '{0, 0, 0, 0, 0, 0, 0};
        vt[4] = '{0, 8, 2, 1, 0, 8, 14};
        vt[5] = '{4, 3, 0, 5, 8, 7, 12};
        vt[6] = '{20, 2, 0, 5, 8, 6, 99};
        vt[7] = '{0, 4, 0, 1, 0, 4, 6};
        s.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("reset valid", s.out_valid, 0);
        chk("reset last", s.out_last, 0);
        chk("reset in", s.out_input, 0);
        chk("reset wt", s.out_weight, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        rst_n = 1;
        for (int i = 0; i < 16; i++) begin
            m_in[i] = 8'(i + 1);
            m_wt[i] = 8'(2 * i);
            wr_en   = 1;
            wr_sel  = 0;
            wr_addr = 8'(i < 8 ? i : i + 16);
            wr_data = m_in[i];
            @(negedge clk);
            wr_sel  = 1;
            wr_addr = 8'(i);
            wr_data = m_wt[i];
            @(negedge clk);
        end
        wr_en = 0;
        for (int i = 0; i < 7; i++) run(i);
        @(negedge clk);
        base_addr   = 0;
        length      = 8;
        start       = 1;
        s.out_ready = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        chk("pre_reset valid", s.out_valid, 1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("mid_reset valid", s.out_valid, 0);
        chk("mid_reset last", s.out_last, 0);
        chk("mid_reset in", s.out_input, 0);
        chk("mid_reset wt", s.out_weight, 0);
        chk("mid_reset busy", busy, 0);
        chk("mid_reset done", done, 0);
        repeat (3) @(negedge clk);
        chk("post_reset idle valid", s.out_valid, 0);
        chk("post_reset idle done", done, 0);
        run(7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
